get_reg: RTL and testbench
==========================

# get_reg

Register-name lookup for the RISC-V disassembler. Given three 5-bit register indices (rd, rs1, rs2) from a decoded instruction, it returns each register's assembler name as packed ASCII. The decoder's text formatter consumes these names. Outputs are registered with one-cycle latency.

## Interface

Parameters:
- ABI_NAMES, default 1: 1 selects ABI mnemonics (zero, ra, sp, …); 0 selects architectural names (x0…x31).

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies the three index inputs this cycle.
- rd_idx  input  5  destination register index.
- rs1_idx  input  5  source-1 register index.
- rs2_idx  input  5  source-2 register index.
- out_valid  output  1  names and lengths below are valid.
- rd_name  output  32  ASCII name for rd_idx.
- rs1_name  output  32  ASCII name for rs1_idx.
- rs2_name  output  32  ASCII name for rs2_idx.
- rd_len  output  3  character count of rd_name (2–4).
- rs1_len  output  3  character count of rs1_name.
- rs2_len  output  3  character count of rs2_name.

## Operation

- The three lookups are identical and independent. Any index may equal any other.
- String packing:
  - right-justified, last character in bits [7:0];
  - unused upper bytes are 0x00, so a %s print shows only the name;
  - lowercase ASCII.
- ABI_NAMES=1 mapping:
  - 0 zero, 1 ra, 2 sp, 3 gp, 4 tp;
  - 5–7 t0–t2;
  - 8 s0 (never "fp"), 9 s1;
  - 10–17 a0–a7;
  - 18–27 s2–s11;
  - 28–31 t3–t6.
- ABI_NAMES=0 mapping: "x" followed by the decimal index with no leading zero, e.g. 5 → "x5", 31 → "x31".
- Length outputs:
  - len = number of nonzero bytes in the name;
  - "zero" = 4; s10/s11 = 3;
  - with ABI_NAMES=0, x10–x31 = 3 and x0–x9 = 2.
- Every 5-bit index has a defined name; there is no illegal-input case.
- When in_valid=1, all name and len registers load the new lookups.
- When in_valid=0, name and len registers hold their previous values.
- out_valid is in_valid registered.

## Timing

- Latency is 1 cycle: indices sampled at edge N appear on the outputs after edge N, with out_valid=1.
- Throughput is one lookup triple per cycle; back-to-back in_valid is supported with no bubbles.
- No backpressure; the consumer must take the outputs when out_valid=1.
- Reset:
  - while rst=1 at a clock edge: out_valid←0, all *_name←0, all *_len←0;
  - rst has priority over a simultaneous in_valid;
  - the first valid output is one cycle after the first in_valid sampled with rst=0;
  - a lookup in flight when rst asserts is discarded.
- Outputs come directly from flops; no combinational input-to-output path.

## Test plan

- Reset, then in_valid=1 with rd=0, rs1=1, rs2=2 (ABI_NAMES=1). Next cycle:
  - out_valid=1;
  - rd_name=0x7A65726F ("zero");
  - rs1_name=0x00007261 ("ra");
  - rs2_name=0x00007370 ("sp");
  - lens 4/2/2.
- Indices 26, 27, 8 (ABI_NAMES=1):
  - "s10" = 0x00733130;
  - "s11" = 0x00733131;
  - "s0" = 0x00007330;
  - lens 3/3/2.
- Sweep all 32 indices on rd with rs1=rs2=rd, back-to-back:
  - each cycle, all three outputs are equal and match the mapping;
  - boundaries: 17→"a7", 18→"s2", 27→"s11", 28→"t3", 31→"t6".
- ABI_NAMES=0 with indices 0, 9, 31:
  - "x0" = 0x00007830;
  - "x9" = 0x00007839;
  - "x31" = 0x00783331;
  - lens 2/2/3.
- After a valid lookup, drop in_valid for 3 cycles:
  - names are held;
  - out_valid=0 from the cycle after in_valid falls.
- Assert rst in the same cycle as in_valid=1 (idx 5): next cycle out_valid=0 and all outputs 0.

Source files
------------

// File: rtl/get_reg.sv
// Register-index to assembler-name lookup for the disassembler text path.
// Three independent lookups, right-justified packed ASCII, one-cycle registered latency.
module get_reg #(
  parameter int ABI_NAMES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  rd_idx,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  output logic        out_valid,
  output logic [31:0] rd_name,
  output logic [31:0] rs1_name,
  output logic [31:0] rs2_name,
  output logic [2:0]  rd_len,
  output logic [2:0]  rs1_len,
  output logic [2:0]  rs2_len
);

  function automatic logic [7:0] digit(input logic [4:0] val, input logic [7:0] base);
    digit = 8'h30 + {3'b000, val} - base;
  endfunction

  function automatic logic [31:0] abi_name(input logic [4:0] idx);
    logic [31:0] n;
    case (idx) inside
      5'd0:            n = 32'h7A65726F;
      5'd1:            n = 32'h00007261;
      5'd2:            n = 32'h00007370;
      5'd3:            n = 32'h00006770;
      5'd4:            n = 32'h00007470;
      [5'd5:5'd7]:     n = {16'h0000, 8'h74, digit(idx, 8'd5)};
      [5'd8:5'd9]:     n = {16'h0000, 8'h73, digit(idx, 8'd8)};
      [5'd10:5'd17]:   n = {16'h0000, 8'h61, digit(idx, 8'd10)};
      [5'd18:5'd25]:   n = {16'h0000, 8'h73, digit(idx, 8'd16)};
      [5'd26:5'd27]:   n = {8'h00, 8'h73, 8'h31, digit(idx, 8'd26)};
      [5'd28:5'd31]:   n = {16'h0000, 8'h74, digit(idx, 8'd25)};
      default:         n = 32'h00000000;
    endcase
    return n;
  endfunction

  // Architectural form: "x" plus decimal index, tens digit only when idx >= 10.
  function automatic logic [31:0] arch_name(input logic [4:0] idx);
    logic [31:0] n;
    if (idx < 5'd10) begin
      n = {16'h0000, 8'h78, digit(idx, 8'd0)};
    end else if (idx < 5'd20) begin
      n = {8'h00, 8'h78, 8'h31, digit(idx, 8'd10)};
    end else if (idx < 5'd30) begin
      n = {8'h00, 8'h78, 8'h32, digit(idx, 8'd20)};
    end else begin
      n = {8'h00, 8'h78, 8'h33, digit(idx, 8'd30)};
    end
    return n;
  endfunction

  function automatic logic [31:0] reg_name(input logic [4:0] idx);
    if (ABI_NAMES != 0) begin
      return abi_name(idx);
    end else begin
      return arch_name(idx);
    end
  endfunction

  function automatic logic [2:0] name_len(input logic [31:0] n);
    return {2'b00, |n[31:24]} + {2'b00, |n[23:16]} + {2'b00, |n[15:8]} + {2'b00, |n[7:0]};
  endfunction

  logic [31:0] rd_name_s, rs1_name_s, rs2_name_s;
  logic [31:0] rd_name_r, rs1_name_r, rs2_name_r;
  logic [2:0]  rd_len_r, rs1_len_r, rs2_len_r;
  logic        out_valid_r;

  // Combinational name lookup for the three indices.
  always_comb begin
    rd_name_s  = reg_name(rd_idx);
    rs1_name_s = reg_name(rs1_idx);
    rs2_name_s = reg_name(rs2_idx);
  end

  // Output registers: reset clears, in_valid loads, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      rd_name_r   <= 32'h00000000;
      rs1_name_r  <= 32'h00000000;
      rs2_name_r  <= 32'h00000000;
      rd_len_r    <= 3'd0;
      rs1_len_r   <= 3'd0;
      rs2_len_r   <= 3'd0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        rd_name_r  <= rd_name_s;
        rs1_name_r <= rs1_name_s;
        rs2_name_r <= rs2_name_s;
        rd_len_r   <= name_len(rd_name_s);
        rs1_len_r  <= name_len(rs1_name_s);
        rs2_len_r  <= name_len(rs2_name_s);
      end else begin
        rd_name_r  <= rd_name_r;
        rs1_name_r <= rs1_name_r;
        rs2_name_r <= rs2_name_r;
        rd_len_r   <= rd_len_r;
        rs1_len_r  <= rs1_len_r;
        rs2_len_r  <= rs2_len_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign rd_name   = rd_name_r;
  assign rs1_name  = rs1_name_r;
  assign rs2_name  = rs2_name_r;
  assign rd_len    = rd_len_r;
  assign rs1_len   = rs1_len_r;
  assign rs2_len   = rs2_len_r;

endmodule

// File: tb/tb_get_reg.sv
// Directed bench for get_reg: one ABI-name instance and one architectural-name instance
// driven from the same inputs.
module tb_get_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  rd_idx = 5'd0, rs1_idx = 5'd0, rs2_idx = 5'd0;

  logic        a_valid, x_valid;
  logic [31:0] a_rd, a_rs1, a_rs2, x_rd, x_rs1, x_rs2;
  logic [2:0]  a_rdl, a_rs1l, a_rs2l, x_rdl, x_rs1l, x_rs2l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  get_reg #(.ABI_NAMES(1)) dut_abi (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .rd_idx(rd_idx), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .out_valid(a_valid),
    .rd_name(a_rd), .rs1_name(a_rs1), .rs2_name(a_rs2),
    .rd_len(a_rdl), .rs1_len(a_rs1l), .rs2_len(a_rs2l)
  );

  get_reg #(.ABI_NAMES(0)) dut_arch (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .rd_idx(rd_idx), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .out_valid(x_valid),
    .rd_name(x_rd), .rs1_name(x_rs1), .rs2_name(x_rs2),
    .rd_len(x_rdl), .rs1_len(x_rs1l), .rs2_len(x_rs2l)
  );

  string abi_tbl [32] = '{
    "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
    "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
    "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
    "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input string s);
    logic [31:0] v;
    v = 32'h00000000;
    for (int i = 0; i < s.len(); i++) v = {v[23:0], s[i]};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    in_valid = v;
    rd_idx   = d;
    rs1_idx  = s1;
    rs2_idx  = s2;
  endtask

  initial begin
    string xs;
    #1;
    step();
    step();
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_rd", a_rd, 32'h0);
    check("rst_rs1", a_rs1, 32'h0);
    check("rst_rs2", a_rs2, 32'h0);
    check("rst_lens", {23'd0, a_rdl, a_rs1l, a_rs2l}, 32'd0);
    check("rst_x_valid", {31'd0, x_valid}, 32'd0);
    rst = 1'b0;

    drive(1'b1, 5'd0, 5'd1, 5'd2);
    step();
    check("first_valid", {31'd0, a_valid}, 32'd1);
    check("zero_name", a_rd, 32'h7A65726F);
    check("ra_name", a_rs1, 32'h00007261);
    check("sp_name", a_rs2, 32'h00007370);
    check("lens_4_2_2", {23'd0, a_rdl, a_rs1l, a_rs2l}, {23'd0, 3'd4, 3'd2, 3'd2});

    drive(1'b1, 5'd26, 5'd27, 5'd8);
    step();
    check("s10_name", a_rd, 32'h00733130);
    check("s11_name", a_rs1, 32'h00733131);
    check("s0_name", a_rs2, 32'h00007330);
    check("lens_3_3_2", {23'd0, a_rdl, a_rs1l, a_rs2l}, {23'd0, 3'd3, 3'd3, 3'd2});

    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 5'(i), 5'(i));
      step();
      xs = $sformatf("x%0d", i);
      check($sformatf("sweep_valid_%0d", i), {31'd0, a_valid}, 32'd1);
      check($sformatf("sweep_rd_%0d", i), a_rd, pack(abi_tbl[i]));
      check($sformatf("sweep_rs1_%0d", i), a_rs1, pack(abi_tbl[i]));
      check($sformatf("sweep_rs2_%0d", i), a_rs2, pack(abi_tbl[i]));
      check($sformatf("sweep_len_%0d", i), {29'd0, a_rdl}, abi_tbl[i].len());
      check($sformatf("sweep_lens_eq_%0d", i), {26'd0, a_rs1l, a_rs2l}, {26'd0, a_rdl, a_rdl});
      check($sformatf("sweep_x_rd_%0d", i), x_rd, pack(xs));
      check($sformatf("sweep_x_rs2_%0d", i), x_rs2, pack(xs));
      check($sformatf("sweep_x_len_%0d", i), {29'd0, x_rs1l}, xs.len());
      if (i == 17) check("bound_a7", a_rd, 32'h00006137);
      if (i == 18) check("bound_s2", a_rd, 32'h00007332);
      if (i == 27) check("bound_s11", a_rd, 32'h00733131);
      if (i == 28) check("bound_t3", a_rd, 32'h00007433);
      if (i == 31) check("bound_t6", a_rd, 32'h00007436);
    end

    drive(1'b1, 5'd0, 5'd9, 5'd31);
    step();
    check("x0_name", x_rd, 32'h00007830);
    check("x9_name", x_rs1, 32'h00007839);
    check("x31_name", x_rs2, 32'h00783331);
    check("x_lens_2_2_3", {23'd0, x_rdl, x_rs1l, x_rs2l}, {23'd0, 3'd2, 3'd2, 3'd3});

    drive(1'b0, 5'd5, 5'd6, 5'd7);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hold_valid_%0d", k), {31'd0, a_valid}, 32'd0);
      check($sformatf("hold_rd_%0d", k), a_rd, 32'h7A65726F);
      check($sformatf("hold_rs1_%0d", k), a_rs1, 32'h00007331);
      check($sformatf("hold_rs2_%0d", k), a_rs2, 32'h00007436);
      check($sformatf("hold_lens_%0d", k), {23'd0, a_rdl, a_rs1l, a_rs2l}, {23'd0, 3'd4, 3'd2, 3'd2});
      check($sformatf("hold_x_rs2_%0d", k), x_rs2, 32'h00783331);
    end

    rst = 1'b1;
    drive(1'b1, 5'd5, 5'd5, 5'd5);
    step();
    check("rstpri_valid", {31'd0, a_valid}, 32'd0);
    check("rstpri_rd", a_rd, 32'h0);
    check("rstpri_rs1", a_rs1, 32'h0);
    check("rstpri_rs2", a_rs2, 32'h0);
    check("rstpri_lens", {23'd0, a_rdl, a_rs1l, a_rs2l}, 32'd0);
    check("rstpri_x_rd", x_rd, 32'h0);

    rst = 1'b0;
    step();
    check("post_rst_valid", {31'd0, a_valid}, 32'd1);
    check("post_rst_t0", a_rd, 32'h00007430);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
